instr_decode_stage: RTL and testbench

//  Registered instruction-decode pipeline stage between fetch and execute. Accepts 32-bit

---
 rtl/instr_decode_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_instr_decode_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// Registered instruction-decode stage with a 2-entry skid buffer (out reg + skid reg).
// Optional perf counters (perf_decoded/perf_illegal) are enabled by defining DECODE_PERF_CNT_EN.
module instr_decode_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_op,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_cond,
    output logic [XLEN-1:0] out_imm,
    output logic [PC_W-1:0] out_pc,
    output logic            out_uses_rs1,
    output logic            out_uses_rs2,
    output logic            out_writes_rd,
    output logic            out_illegal
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]     perf_decoded,
    output logic [31:0]     perf_illegal
`endif
);

    localparam int unsigned CNT_W = 32;

    localparam logic [6:0] OP_NOP    = 7'h00;
    localparam logic [6:0] OP_LD     = 7'h03;
    localparam logic [6:0] OP_ARITHI = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_ST     = 7'h23;
    localparam logic [6:0] OP_ARITH  = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BR     = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef struct packed {
        logic [6:0]      op;
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      cond;
        logic [XLEN-1:0] imm;
        logic [PC_W-1:0] pc;
        logic            uses_rs1;
        logic            uses_rs2;
        logic            writes_rd;
        logic            illegal;
    } bundle_t;

    bundle_t         dec;
    bundle_t         out_q;
    bundle_t         skid_q;
    logic            skid_valid;
    logic            in_fire;

    logic [6:0]      f_op;
    logic [2:0]      f_funct3;
    logic [4:0]      f_rd;
    logic [4:0]      f_rs1;
    logic [4:0]      f_rs2;
    logic [6:0]      f_funct7;
    logic            use1;
    logic            use2;
    logic            wr;
    logic            bad;
    logic [4:0]      cond;
    logic [XLEN-1:0] imm;

    assign f_op     = in_instr[6:0];
    assign f_rd     = in_instr[11:7];
    assign f_funct3 = in_instr[14:12];
    assign f_rs1    = in_instr[19:15];
    assign f_rs2    = in_instr[24:20];
    assign f_funct7 = in_instr[31:25];
    assign in_fire  = in_valid & in_ready;

    // Opcode class decode: operand usage, immediate format and encoding legality
    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        wr   = 1'b0;
        bad  = 1'b0;
        cond = 5'd0;
        imm  = '0;
        case (f_op)
            OP_ARITH: begin
                use1 = 1'b1;
                use2 = 1'b1;
                wr   = 1'b1;
                bad  = (f_funct7 != 7'd0);
            end
            OP_ARITHI, OP_JALR: begin
                use1 = 1'b1;
                wr   = 1'b1;
                imm  = XLEN'($signed(in_instr[31:20]));
            end
            OP_LD: begin
                use1 = 1'b1;
                wr   = 1'b1;
                imm  = XLEN'($signed(in_instr[31:20]));
                bad  = (f_funct3 inside {3'd3, 3'd6, 3'd7});
            end
            OP_ST: begin
                use1 = 1'b1;
                use2 = 1'b1;
                imm  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
                bad  = (f_funct3 > 3'd2);
            end
            OP_LUI, OP_AUIPC: begin
                wr  = 1'b1;
                imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            end
            OP_JAL: begin
                wr  = 1'b1;
                imm = XLEN'($signed({in_instr[31:12], 1'b0}));
            end
            OP_BR: begin
                cond = f_rd;
                imm  = XLEN'($signed({in_instr[31:12], 1'b0}));
                bad  = (f_rd > 5'd12);
            end
            OP_NOP: ;
            default: bad = 1'b1;
        endcase
        if (use1 && (32'(f_rs1) >= NUM_REGS)) bad = 1'b1;
        if (use2 && (32'(f_rs2) >= NUM_REGS)) bad = 1'b1;
        if (wr   && (32'(f_rd)  >= NUM_REGS)) bad = 1'b1;
    end

    // Assemble the bundle; illegal instructions carry only op/funct3/pc
    always_comb begin
        dec        = '0;
        dec.op     = f_op;
        dec.funct3 = f_funct3;
        dec.pc     = in_pc;
        dec.illegal = bad;
        if (!bad) begin
            dec.uses_rs1  = use1;
            dec.uses_rs2  = use2;
            dec.writes_rd = wr && (f_rd != 5'd0);
            dec.rd        = (wr && (f_rd != 5'd0)) ? f_rd : 5'd0;
            dec.rs1       = use1 ? f_rs1 : 5'd0;
            dec.rs2       = use2 ? f_rs2 : 5'd0;
            dec.cond      = cond;
            dec.imm       = imm;
        end
    end

    // Skid buffer: in_ready is registered as "skid will be empty next cycle"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
                in_ready   <= 1'b1;
            end else if (in_fire) begin
                out_q     <= dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
        end
    end

    assign out_op        = out_q.op;
    assign out_funct3    = out_q.funct3;
    assign out_rd        = out_q.rd;
    assign out_rs1       = out_q.rs1;
    assign out_rs2       = out_q.rs2;
    assign out_cond      = out_q.cond;
    assign out_imm       = out_q.imm;
    assign out_pc        = out_q.pc;
    assign out_uses_rs1  = out_q.uses_rs1;
    assign out_uses_rs2  = out_q.uses_rs2;
    assign out_writes_rd = out_q.writes_rd;
    assign out_illegal   = out_q.illegal;

`ifdef DECODE_PERF_CNT_EN
    // Delivery counters; flush does not touch them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_decoded <= '0;
            perf_illegal <= '0;
        end else if (out_valid && out_ready) begin
            perf_decoded <= perf_decoded + CNT_W'(1);
            if (out_q.illegal) perf_illegal <= perf_illegal + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage (XLEN=64, NUM_REGS=16); perf counters are
// checked when DECODE_PERF_CNT_EN is defined.
module tb_instr_decode_stage;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  cond;
        logic [63:0] imm;
        logic [31:0] pc;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        writes_rd;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [6:0]  out_op;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd, out_rs1, out_rs2, out_cond;
    logic [63:0] out_imm;
    logic [31:0] out_pc;
    logic        out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_decoded, perf_illegal;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    int   model_decoded = 0;
    int   model_illegal = 0;
    exp_t exp_q[$];
    exp_t mon_exp;
    exp_t mon_act;

    instr_decode_stage #(.XLEN(64), .NUM_REGS(16), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_funct3(out_funct3), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_cond(out_cond), .out_imm(out_imm), .out_pc(out_pc),
        .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2),
        .out_writes_rd(out_writes_rd), .out_illegal(out_illegal)
`ifdef DECODE_PERF_CNT_EN
        , .perf_decoded(perf_decoded), .perf_illegal(perf_illegal)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [6:0] op, input logic [2:0] f3,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] cond,
                                input logic [63:0] imm, input logic [31:0] pc,
                                input logic u1, input logic u2, input logic w,
                                input logic ill);
        exp_t e;
        e.op = op; e.funct3 = f3; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.cond = cond;
        e.imm = imm; e.pc = pc; e.uses_rs1 = u1; e.uses_rs2 = u2; e.writes_rd = w;
        e.illegal = ill;
        return e;
    endfunction

    function automatic exp_t mk_ill(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [31:0] pc);
        return mk(op, f3, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0, pc, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Offer one instruction; the expectation is queued only once the handshake is certain
    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: pc 0x%0h never accepted", pc);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every delivered bundle is checked against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            vectors++;
            mon_act = {out_op, out_funct3, out_rd, out_rs1, out_rs2, out_cond, out_imm, out_pc,
                       out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal};
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_out: got bundle pc 0x%0h, expected no output", out_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                model_decoded++;
                if (mon_exp.illegal) model_illegal++;
                if (mon_act !== mon_exp) begin
                    miscompares++;
                    $display("FAIL bundle pc 0x%0h: got 0x%0h, expected 0x%0h",
                             mon_exp.pc, mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_imm", out_imm, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed decode vectors, back to back with execute always ready
        out_ready = 1'b1;
        send(32'hFFF08293, 32'h100, mk(7'h13, 3'd0, 5'd5, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h100, 1, 0, 1, 0));
        send(32'h800001B7, 32'h104, mk(7'h37, 3'd0, 5'd3, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_8000_0000, 32'h104, 0, 0, 1, 0));
        send(32'h003100B3, 32'h108, mk(7'h33, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 64'd0, 32'h108, 1, 1, 1, 0));
        send(32'h00412423, 32'h10C, mk(7'h23, 3'd2, 5'd0, 5'd2, 5'd4, 5'd0, 64'd8, 32'h10C, 1, 1, 0, 0));
        send(32'h001000EF, 32'h110, mk(7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 5'd0, 64'h200, 32'h110, 0, 0, 1, 0));
        send(32'hFFFFF2E3, 32'h114, mk(7'h63, 3'd7, 5'd0, 5'd0, 5'd0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 32'h114, 0, 0, 0, 0));
        send(32'h12345397, 32'h118, mk(7'h17, 3'd5, 5'd7, 5'd0, 5'd0, 5'd0, 64'h1234_5000, 32'h118, 0, 0, 1, 0));
        send(32'h00008067, 32'h11C, mk(7'h67, 3'd0, 5'd0, 5'd1, 5'd0, 5'd0, 64'd0, 32'h11C, 1, 0, 0, 0));
        send(32'hFFC7A103, 32'h120, mk(7'h03, 3'd2, 5'd2, 5'd15, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h120, 1, 0, 1, 0));
        send(32'h00000000, 32'h124, mk(7'h00, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0, 32'h124, 0, 0, 0, 0));
        send(32'h011100B3, 32'h128, mk_ill(7'h33, 3'd0, 32'h128));
        send(32'h00006083, 32'h12C, mk_ill(7'h03, 3'd6, 32'h12C));
        send(32'h000006E3, 32'h130, mk_ill(7'h63, 3'd0, 32'h130));
        send(32'h0000007F, 32'h134, mk_ill(7'h7F, 3'd0, 32'h134));
        send(32'h00000A13, 32'h138, mk_ill(7'h13, 3'd0, 32'h138));
        send(32'h403100B3, 32'h13C, mk_ill(7'h33, 3'd0, 32'h13C));
        idle(3);

        // Backpressure: two captured, third waits until the stage drains
        out_ready = 1'b0;
        send(32'h00108093, 32'h200, mk(7'h13, 3'd0, 5'd1, 5'd1, 5'd0, 5'd0, 64'd1, 32'h200, 1, 0, 1, 0));
        send(32'h00210113, 32'h204, mk(7'h13, 3'd0, 5'd2, 5'd2, 5'd0, 5'd0, 64'd2, 32'h204, 1, 0, 1, 0));
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        idle(2);
        @(negedge clk);
        chk("held_out_pc", 64'(out_pc), 64'h200);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(32'h00318193, 32'h208, mk(7'h13, 3'd0, 5'd3, 5'd3, 5'd0, 5'd0, 64'd3, 32'h208, 1, 0, 1, 0));
        idle(4);

        // Flush with both entries full and an input offered
        out_ready = 1'b0;
        send(32'h00420213, 32'h300, mk(7'h13, 3'd0, 5'd4, 5'd4, 5'd0, 5'd0, 64'd4, 32'h300, 1, 0, 1, 0));
        send(32'h00528293, 32'h304, mk(7'h13, 3'd0, 5'd5, 5'd5, 5'd0, 5'd0, 64'd5, 32'h304, 1, 0, 1, 0));
        in_valid = 1'b1; in_instr = 32'h00630313; in_pc = 32'h308; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_full_out_valid", 64'(out_valid), 64'd0);
        chk("flush_full_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        idle(4);

        // Flush with room available: the same-cycle input must still be dropped
        out_ready = 1'b0;
        send(32'h00738393, 32'h400, mk(7'h13, 3'd0, 5'd7, 5'd7, 5'd0, 5'd0, 64'd7, 32'h400, 1, 0, 1, 0));
        in_valid = 1'b1; in_instr = 32'h00840413; in_pc = 32'h404; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_part_out_valid", 64'(out_valid), 64'd0);
        chk("flush_part_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        idle(4);

        // Drain check
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

`ifdef DECODE_PERF_CNT_EN
        @(negedge clk);
        chk("perf_decoded", 64'(perf_decoded), 64'(model_decoded));
        chk("perf_illegal", 64'(perf_illegal), 64'(model_illegal));
        rst = 1'b1;
        @(negedge clk);
        chk("perf_decoded_rst", 64'(perf_decoded), 64'd0);
        chk("perf_illegal_rst", 64'(perf_illegal), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
